// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and widths for the sequential multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  // Default operand width and its iteration-counter width
  localparam int MULT_N = 32;
  localparam int CNT_W  = $clog2(MULT_N);

endpackage

// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - operand/result handshake bundle for seq_multiplier
interface seq_multiplier_if #(
  parameter int N = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result_lo;
  logic [N-1:0] result_hi;
  logic         z_flag;
  logic         n_flag;
  logic         c_flag;
  logic         v_flag;
  logic         busy;

  // Producer of operands / consumer of products
  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, result_lo, result_hi,
    input  z_flag, n_flag, c_flag, v_flag, busy
  );

  // The multiplier itself
  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, result_lo, result_hi,
    output z_flag, n_flag, c_flag, v_flag, busy
  );

endinterface

// File: rtl/seq_multiplier_negate.sv
// rtl/seq_multiplier_negate.sv - combinational conditional two's-complement negate
module twos_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  // The most-negative value maps onto itself, which read as unsigned is its magnitude
  assign y = en ? (~x + W'(1)) : x;

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative radix-2 shift-add multiplier, full 2N-bit product
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int N = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_multiplier_if.slave    bus
);

  localparam int CW = $clog2(N);

  mult_state_t     state_q, state_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            sgn_q, sgn_d;
  logic [N-1:0]    res_lo_q, res_lo_d;
  logic [N-1:0]    res_hi_q, res_hi_d;
  logic            z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic            out_valid_q, out_valid_d;

  logic [N-1:0]    mag_a, mag_b;
  logic [2*N-1:0]  acc_fin;
  logic [N:0]      sum;

  twos_negate #(.W(N)) u_neg_a (
    .en (bus.is_signed & bus.a[N-1]),
    .x  (bus.a),
    .y  (mag_a)
  );

  twos_negate #(.W(N)) u_neg_b (
    .en (bus.is_signed & bus.b[N-1]),
    .x  (bus.b),
    .y  (mag_b)
  );

  twos_negate #(.W(2*N)) u_neg_acc (
    .en (neg_q),
    .x  (acc_q),
    .y  (acc_fin)
  );

  // Upper accumulator half plus the multiplicand when the current multiplier bit is set
  assign sum = {1'b0, acc_q[2*N-1:N]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

  // Next-state and datapath updates for the IDLE -> CALC -> FIX -> DONE sequence
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    sgn_d       = sgn_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    z_d         = z_q;
    n_d         = n_q;
    c_d         = c_q;
    v_d         = v_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = mag_a;
          mplier_d = mag_b;
          neg_d    = bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
          sgn_d    = bus.is_signed;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = (bus.a == '0 || bus.b == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        acc_d    = {sum, acc_q[N-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        res_lo_d = acc_fin[N-1:0];
        res_hi_d = acc_fin[2*N-1:N];
        z_d      = (acc_fin[N-1:0] == '0);
        n_d      = acc_fin[N-1];
        c_d      = ~sgn_q & (acc_fin[2*N-1:N] != '0);
        v_d      = sgn_q & (acc_fin[2*N-1:N] != {N{acc_fin[N-1]}});
        state_d  = DONE;
      end
      DONE: begin
        // Result registers settle in FIX, so out_valid follows one cycle into DONE
        out_valid_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      sgn_q       <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      sgn_q       <= sgn_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      z_q         <= z_d;
      n_q         <= n_d;
      c_q         <= c_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.z_flag    = z_q;
  assign bus.n_flag    = n_q;
  assign bus.c_flag    = c_q;
  assign bus.v_flag    = v_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier at N=8
module tb_seq_multiplier;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_multiplier_if #(.N(N)) bus ();

  seq_multiplier #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // {hi, lo, z, n, c, v}
  typedef logic [2*N+3:0] resp_t;

  resp_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic resp_t exp_r(input logic [N-1:0] hi, input logic [N-1:0] lo,
                                  input logic z, input logic n, input logic c, input logic v);
    return {hi, lo, z, n, c, v};
  endfunction

  function automatic resp_t snap();
    return {bus.result_hi, bus.result_lo, bus.z_flag, bus.n_flag, bus.c_flag, bus.v_flag};
  endfunction

  // Monitor: every accepted product is popped and compared against the scoreboard
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got 0x%0h expected none", snap());
      end else begin
        check("scoreboard", 32'(snap()), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    @(negedge clk);
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int c = 0;
    while (!bus.out_valid && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(name, 32'(c), 32'(exp_lat));
  endtask

  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic s, input resp_t exp, input int lat);
    exp_q.push_back(exp);
    issue(a, b, s);
    wait_valid(name, lat);
    @(posedge clk);
    #1 check("out_valid_drop", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    #1;
    check("reset_ready_valid_busy", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
    check("reset_result", 32'(snap()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_op("lat_ff_ff", 8'hFF, 8'hFF, 1'b0, exp_r(8'hFE, 8'h01, 0, 0, 1, 0), 10);
    run_op("lat_m3_5",  8'hFD, 8'h05, 1'b1, exp_r(8'hFF, 8'hF1, 0, 1, 0, 0), 10);
    run_op("lat_80_80", 8'h80, 8'h80, 1'b1, exp_r(8'h40, 8'h00, 1, 0, 0, 1), 10);
    run_op("lat_zero",  8'h00, 8'h37, 1'b0, exp_r(8'h00, 8'h00, 1, 0, 0, 0), 2);

    // Back-pressure in DONE with stray in_valid pulses
    bus.out_ready = 1'b0;
    exp_q.push_back(exp_r(8'h03, 8'hA8, 0, 1, 1, 0));
    issue(8'h12, 8'h34, 1'b0);
    wait_valid("lat_hold", 10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = ~bus.in_valid;
      bus.a        = 8'h55;
      bus.b        = 8'h55;
      @(negedge clk);
      check("hold_valid_ready", 32'({bus.out_valid, bus.in_ready}), 32'b10);
      check("hold_result", 32'(snap()), 32'(exp_r(8'h03, 8'hA8, 0, 1, 1, 0)));
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 check("after_release_valid_ready", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    run_op("lat_7_6", 8'h07, 8'h06, 1'b0, exp_r(8'h00, 8'h2A, 0, 0, 0, 0), 10);

    // Reset during CALC at iteration 3
    issue(8'hFF, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("busy_in_calc", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_ready_valid_busy", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
    check("midreset_result", 32'(snap()), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      check("no_valid_after_reset", 32'(seen), 32'd0);
    end
    run_op("lat_12_34", 8'h12, 8'h34, 1'b0, exp_r(8'h03, 8'hA8, 0, 1, 1, 0), 10);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
